// File: rtl/seg_scan_decoder.sv
// Deserialises a multiplexed active-low seven-segment scan (AN/BCD) back into a 4-digit hex value.
// Optional SEG_DP_CAPTURE_EN: capture the decimal points per digit and publish them on dp_mask.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [3:0]  AN,
  input  logic [7:0]  BCD,
  output logic [15:0] value,
  output logic [3:0]  dp_mask,
  output logic        frame_valid,
  output logic        frame_pulse,
  output logic        bad_glyph,
  output logic        an_err
);

  logic [11:0] r_s_q;
  logic [7:0]  r_cnt;
  logic [3:0]  r_seen;
  logic [15:0] r_cur;
  logic [19:0] r_prev;
  logic [3:0]  r_match;
  logic [15:0] r_value;
  logic [3:0]  r_dp_mask;
  logic        r_frame_valid;
  logic        r_frame_pulse;
  logic        r_bad_glyph;
  logic        r_an_err;

  logic        w_stable;
  logic        w_settle;
  logic [3:0]  w_sel;
  logic        w_one_hot;
  logic        w_multi;
  logic        w_glyph_ok;
  logic [3:0]  w_nib;
  logic        w_cap;
  logic        w_frame_done;
  logic [3:0]  w_cur_dp;
  logic [19:0] w_frame;
  logic [3:0]  w_match_next;
  logic        w_publish;

  assign w_stable  = ({AN, BCD} == r_s_q);
  // cnt saturates at SETTLE_CYCLES, so this fires once per stable interval
  assign w_settle  = w_stable && (r_cnt == 8'(SETTLE_CYCLES - 1));
  assign w_sel     = ~r_s_q[11:8];
  assign w_one_hot = (w_sel != 4'h0) && ((w_sel & (w_sel - 4'd1)) == 4'h0);
  assign w_multi   = (w_sel != 4'h0) && !w_one_hot;

  always_comb begin
    w_glyph_ok = 1'b1;
    w_nib      = 4'h0;
    case (r_s_q[6:0])
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      default: w_glyph_ok = 1'b0;
    endcase
  end

  assign w_cap        = w_settle && w_one_hot && w_glyph_ok;
  assign w_frame_done = (r_seen == 4'hF);

`ifdef SEG_DP_CAPTURE_EN
  logic [3:0] r_cur_dp;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_cur_dp <= 4'h0;
    end else if (w_cap) begin
      for (int i = 0; i < 4; i++)
        if (w_sel[i]) r_cur_dp[i] <= ~r_s_q[7];
    end
  end

  assign w_cur_dp = r_cur_dp;
`else
  assign w_cur_dp = 4'h0;
`endif

  assign w_frame = {w_cur_dp, r_cur};

  always_comb begin
    w_match_next = 4'd1;
    if (w_frame == r_prev)
      w_match_next = (r_match >= 4'(STABLE_FRAMES)) ? 4'(STABLE_FRAMES) : r_match + 4'd1;
  end

  assign w_publish = w_frame_done && (w_match_next == 4'(STABLE_FRAMES));

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_s_q         <= 12'hFFF;
      r_cnt         <= 8'd0;
      r_seen        <= 4'h0;
      r_cur         <= 16'h0;
      r_prev        <= 20'h0;
      r_match       <= 4'd0;
      r_value       <= 16'h0;
      r_dp_mask     <= 4'h0;
      r_frame_valid <= 1'b0;
      r_frame_pulse <= 1'b0;
      r_bad_glyph   <= 1'b0;
      r_an_err      <= 1'b0;
    end else begin
      r_s_q <= {AN, BCD};
      if (!w_stable)
        r_cnt <= 8'd0;
      else if (r_cnt != 8'(SETTLE_CYCLES))
        r_cnt <= r_cnt + 8'd1;

      r_an_err <= w_settle && w_multi;
      if (w_settle && w_one_hot && !w_glyph_ok)
        r_bad_glyph <= 1'b1;

      // A completed frame is consumed the edge after its last capture
      r_seen <= (w_frame_done ? 4'h0 : r_seen) | (w_cap ? w_sel : 4'h0);
      if (w_cap) begin
        for (int i = 0; i < 4; i++)
          if (w_sel[i]) r_cur[4*i +: 4] <= w_nib;
      end

      if (w_frame_done) begin
        r_prev  <= w_frame;
        r_match <= w_match_next;
      end

      r_frame_pulse <= 1'b0;
      if (w_publish) begin
        r_value       <= r_cur;
        r_dp_mask     <= w_cur_dp;
        r_frame_valid <= 1'b1;
        r_frame_pulse <= !r_frame_valid || (w_frame != {r_dp_mask, r_value});
      end
    end
  end

  assign value       = r_value;
  assign dp_mask     = r_dp_mask;
  assign frame_valid = r_frame_valid;
  assign frame_pulse = r_frame_pulse;
  assign bad_glyph   = r_bad_glyph;
  assign an_err      = r_an_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus randomized scans checked
// against a segment-level model of the scan/frame/publish rules.
module tb_seg_scan_decoder;

  localparam int S  = 4;
  localparam int NF = 2;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic [3:0]  AN     = 4'hF;
  logic [7:0]  BCD    = 8'hFF;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        frame_valid, frame_pulse, bad_glyph, an_err;

  seg_scan_decoder #(.SETTLE_CYCLES(S), .STABLE_FRAMES(NF)) dut (
    .sysclk(sysclk), .reset(reset), .AN(AN), .BCD(BCD),
    .value(value), .dp_mask(dp_mask), .frame_valid(frame_valid),
    .frame_pulse(frame_pulse), .bad_glyph(bad_glyph), .an_err(an_err)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0, failures = 0;
  int pulse_cnt = 0, anerr_cnt = 0;

  always @(negedge sysclk) begin
    if (frame_pulse) pulse_cnt++;
    if (an_err) anerr_cnt++;
  end

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // reference model state
  logic [3:0]  m_cur [4];
  logic [3:0]  m_dp, m_seen, m_dpm;
  logic [19:0] m_prev;
  logic [15:0] m_val;
  logic [11:0] last_in;
  int          m_match, m_pulses, m_anerr;
  bit          m_valid, m_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int decode(input logic [7:0] b);
    logic [7:0] g;
    for (int i = 0; i < 16; i++) begin
      g = glyph[i];
      if (g[6:0] == b[6:0]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cur[i] = 4'h0;
    m_dp = 0; m_seen = 0; m_prev = 0; m_match = 0;
    m_val = 0; m_dpm = 0; m_valid = 0; m_bad = 0;
    last_in = 12'hFFF;
  endtask

  task automatic model_frame();
    logic [19:0] f;
    f[15:0] = {m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
`ifdef SEG_DP_CAPTURE_EN
    f[19:16] = m_dp;
`else
    f[19:16] = 4'h0;
`endif
    if (f == m_prev) m_match = (m_match + 1 > NF) ? NF : m_match + 1;
    else m_match = 1;
    m_prev = f;
    m_seen = 0;
    if (m_match == NF) begin
      if (!m_valid || f != {m_dpm, m_val}) m_pulses++;
      m_val = f[15:0]; m_dpm = f[19:16]; m_valid = 1;
    end
  endtask

  task automatic model_settle(input logic [3:0] an, input logic [7:0] bcd);
    int n_low = 0, d = 0, g;
    for (int i = 0; i < 4; i++)
      if (!an[i]) begin n_low++; d = i; end
    if (n_low == 0) return;
    if (n_low > 1) begin m_anerr++; return; end
    g = decode(bcd);
    if (g < 0) begin m_bad = 1; return; end
    m_cur[d] = g[3:0];
    m_dp[d]  = ~bcd[7];
    m_seen[d] = 1'b1;
    if (m_seen == 4'hF) model_frame();
  endtask

  task automatic check_outputs();
    chk("value", 32'(value), 32'(m_val));
    chk("dp_mask", 32'(dp_mask), 32'(m_dpm));
    chk("frame_valid", 32'(frame_valid), 32'(m_valid));
    chk("bad_glyph", 32'(bad_glyph), 32'(m_bad));
    chk("pulse_count", 32'(pulse_cnt), 32'(m_pulses));
    chk("an_err_count", 32'(anerr_cnt), 32'(m_anerr));
  endtask

  task automatic apply(input logic [3:0] an, input logic [7:0] bcd, input int h);
    AN = an; BCD = bcd;
    repeat (h) @(posedge sysclk);
    #1;
    last_in = {an, bcd};
    if (h >= S + 1) model_settle(an, bcd);
    if (h >= S + 3) check_outputs();
  endtask

  task automatic seg(input logic [3:0] an, input logic [7:0] bcd, input int h);
    if ({an, bcd} == last_in) apply(4'hF, 8'h00, 1);
    apply(an, bcd, h);
  endtask

  function automatic logic [7:0] digit_byte(input logic [3:0] n, input bit dp);
    logic [7:0] b;
    b = glyph[n];
    if (dp) b[7] = 1'b0;
    return b;
  endfunction

  task automatic scan_frame(input logic [15:0] v, input logic [3:0] dp, input int h);
    for (int d = 0; d < 4; d++)
      seg(~(4'b0001 << d), digit_byte(v[4*d +: 4], dp[d]), h);
  endtask

  task automatic do_reset();
    AN = 4'hF; BCD = 8'hFF; reset = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_dp_mask", 32'(dp_mask), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_frame_pulse", 32'(frame_pulse), 32'h0);
    chk("rst_bad_glyph", 32'(bad_glyph), 32'h0);
    chk("rst_an_err", 32'(an_err), 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic noise();
    int r = $urandom_range(0, 19);
    int d = $urandom_range(0, 3);
    logic [3:0] bad_an [4] = '{4'hC, 4'h0, 4'h5, 4'h3};
    if (r < 8)       seg(4'hF, 8'hFF, $urandom_range(1, S + 6));
    else if (r < 15) seg(~(4'b0001 << d), glyph[$urandom_range(0, 15)], $urandom_range(1, S));
    else if (r < 18) seg(bad_an[d], glyph[$urandom_range(0, 15)], $urandom_range(S + 1, S + 6));
    else if (r < 19) seg(~(4'b0001 << d), 8'hFF, $urandom_range(1, S + 6));
    else             seg(~(4'b0001 << d), 8'($urandom_range(1, 254)), $urandom_range(1, S + 6));
  endtask

  initial begin
    int base;
    logic [15:0] tv;
    logic [3:0]  tdp;
    m_pulses = 0; m_anerr = 0;
    model_reset();
    do_reset();

    // steady frame: publish after frame 2, single pulse
    base = pulse_cnt;
    scan_frame(16'h1234, 4'h0, 8);
    chk("steady_valid_f1", 32'(frame_valid), 32'h0);
    scan_frame(16'h1234, 4'h0, 8);
    chk("steady_value_f2", 32'(value), 32'h1234);
    chk("steady_valid_f2", 32'(frame_valid), 32'h1);
    scan_frame(16'h1234, 4'h0, 8);
    chk("steady_one_pulse", 32'(pulse_cnt - base), 32'h1);

    // value change: digit 0 -> F
    scan_frame(16'h123F, 4'h0, 8);
    chk("change_hold_old", 32'(value), 32'h1234);
    scan_frame(16'h123F, 4'h0, 8);
    chk("change_value", 32'(value), 32'h123F);
    chk("change_pulse", 32'(pulse_cnt - base), 32'h2);

    // bad glyph is sticky across good frames
    seg(4'hE, 8'hFF, 8);
    chk("bad_set", 32'(bad_glyph), 32'h1);
    scan_frame(16'h123F, 4'h0, 8);
    scan_frame(16'h123F, 4'h0, 8);
    chk("bad_sticky", 32'(bad_glyph), 32'h1);

    // short glitch on digit 3 never completes a frame
    do_reset();
    for (int k = 0; k < 2; k++) begin
      seg(4'hE, 8'h99, 8); seg(4'hD, 8'hB0, 8); seg(4'hB, 8'hA4, 8);
      seg(4'h7, 8'hF9, S); seg(4'hF, 8'hFF, 8);
    end
    chk("glitch_no_publish", 32'(frame_valid), 32'h0);

    // illegal AN: pulse, and no digits captured
    do_reset();
    base = anerr_cnt;
    for (int k = 0; k < 2; k++) begin
      seg(4'hB, 8'hA4, 8); seg(4'h7, 8'hF9, 8); seg(4'hC, 8'h99, 8);
    end
    chk("an_err_pulses", 32'(anerr_cnt - base), 32'h2);
    chk("an_err_no_capture", 32'(frame_valid), 32'h0);

    // dp on digit 2, then reset mid-frame
    do_reset();
    scan_frame(16'h1234, 4'b0100, 8);
    scan_frame(16'h1234, 4'b0100, 8);
`ifdef SEG_DP_CAPTURE_EN
    chk("dp_mask", 32'(dp_mask), 32'h4);
`else
    chk("dp_mask", 32'(dp_mask), 32'h0);
`endif
    seg(4'hE, 8'h99, 8); seg(4'hD, 8'hB0, 8);
    do_reset();
    scan_frame(16'h1234, 4'b0100, 8);
    chk("rst_needs_2_f1", 32'(frame_valid), 32'h0);
    scan_frame(16'h1234, 4'b0100, 8);
    chk("rst_needs_2_f2", 32'(frame_valid), 32'h1);

    // minimum hold of SETTLE_CYCLES+1 still captures
    do_reset();
    scan_frame(16'hA5C0, 4'h0, S + 1);
    scan_frame(16'hA5C0, 4'h0, S + 1);
    seg(4'hF, 8'hFF, 8);
    chk("min_hold_value", 32'(value), 32'hA5C0);

    // randomized scans against the model
    tv = 16'($urandom); tdp = 4'($urandom);
    for (int fr = 0; fr < 150; fr++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      if ($urandom_range(0, 9) < 3) begin
        tv = 16'($urandom); tdp = 4'($urandom);
      end
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 4) == 0) noise();
        seg(~(4'b0001 << d), digit_byte(tv[4*d +: 4], tdp[d]), $urandom_range(S + 1, S + 6));
      end
    end
    seg(4'hF, 8'hFF, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Synthesizable monitor that observes the multiplexed seven-segment scan driven by `PipelineCPU` (`AN`, `BCD`) and reconstructs the displayed 4-digit hex value. It works in the opposite direction to the CPU's display scanner: the scanner serialises a 16-bit value onto digit strobes, and this block deserialises it. It sits beside the CPU in self-checking benches, and on-chip for loopback debug. A value is published only after consistent full frames, so scan transients and mid-update frames never reach the output.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive stable cycles a digit must hold before capture; legal range 1–255.
- `STABLE_FRAMES`, default 2: identical consecutive complete frames required before publishing; legal range 1–15.

Ports:
- `sysclk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `sysclk` rising edge.
- `AN`  in  4  digit select, active-low; `AN[0]` is the rightmost digit (bits 3:0 of the value).
- `BCD`  in  8  segments, active-low; `BCD[6:0]` = {g,f,e,d,c,b,a}, `BCD[7]` = dp.
- `value`  out  16  last published value; digit i sits in bits 4i+3:4i.
- `dp_mask`  out  4  last published decimal points, active-high, bit i = digit i.
- `frame_valid`  out  1  high once any value has been published; stays high until reset.
- `frame_pulse`  out  1  one-cycle strobe on each publish whose value or dp differs from the current outputs, and on the first publish.
- `bad_glyph`  out  1  sticky; set when a settled pattern is not a hex glyph.
- `an_err`  out  1  one-cycle strobe when a settled `AN` has more than one low bit.

## Operation
- **Input register:** `s_q <= {AN,BCD}` every cycle.
- **Settle counter `cnt`:**
  - Cleared to 0 when `{AN,BCD} != s_q`.
  - Otherwise incremented, saturating at `SETTLE_CYCLES`.
  - A settle event occurs on the edge where `cnt` reaches `SETTLE_CYCLES`; this happens once per stable interval.
- **Handling a settle event, by `AN`:**
  - `AN == 4'b1111` (blank): ignored.
  - More than one bit low: `an_err` pulses; no capture.
  - Exactly one bit low: `BCD[6:0]` is decoded against the standard hex glyphs 0–9 and A, b, C, d, E, F (active-low 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E).
- **Decode result:**
  - Match: the nibble is written to `cur[digit]` and `seen[digit]` is set.
  - No match: `bad_glyph` is set; no capture.
- **Re-capturing a digit** already marked in `seen` overwrites it; the frame does not restart.
- **Frame complete** when `seen == 4'b1111`. `seen` then clears and the frame `{cur, cur_dp}` is compared with the previous complete frame:
  - Equal: `match` increments, saturating at `STABLE_FRAMES`.
  - Different: `match` is set to 1.
  - Publish when `match` reaches `STABLE_FRAMES`. The frame is copied to `value`/`dp_mask`, `frame_valid` is set, and `frame_pulse` fires only if the published data changed or this is the first publish.
  - With `STABLE_FRAMES == 1`, every complete frame publishes.
- **Reset values:**
  - Outputs: `value=0`, `dp_mask=0`, `frame_valid=0`, `frame_pulse=0`, `bad_glyph=0`, `an_err=0`.
  - Internal state: `s_q=12'hFFF`, `cnt=0`, `seen=0`, `match=0`, previous-frame register cleared.
- **Reset mid-frame:** discards partial frame and match history; the next publish again needs `STABLE_FRAMES` frames.

## Timing
- Input change sampled at edge k:
  - `cnt=0` at edge k.
  - Capture at edge k+`SETTLE_CYCLES`.
  - A digit must therefore be held at least `SETTLE_CYCLES`+1 cycles.
- `value`, `dp_mask`, `frame_valid` and `frame_pulse` update one edge after the capture that completes the publishing frame.
- `an_err` asserts one edge after the offending settle event.
- `bad_glyph` rises one edge after the offending settle event.
- Simultaneous reset and capture: reset wins.
- `cnt` saturation prevents repeat captures of a held digit.

## Configuration
- `SEG_DP_CAPTURE_EN` defined:
  - `BCD[7]` is captured per digit into `cur_dp`.
  - dp takes part in the frame comparison and appears on `dp_mask`.
- Undefined:
  - `BCD[7]` is ignored everywhere.
  - `dp_mask` is tied to 0.
  - Frame comparison covers only the nibbles.

## Test plan
- **Steady frame:** defaults; scan AN=E/D/B/7 with BCD=99/B0/A4/F9, 8 cycles per digit, 3 frames → `value=16'h1234`, `frame_valid=1`, exactly one `frame_pulse`, issued after frame 2.
- **Short glitch:** one digit held only 4 cycles → not captured; frame incomplete; no publish.
- **Illegal `AN`:** settled `AN=4'b1100` → `an_err` one pulse; `seen` unchanged.
- **Bad glyph:** settled BCD=8'hFF on digit 0 → `bad_glyph=1` and stays 1 through later good frames until `reset`.
- **Value change:** after 1234 is published, switch the digit-0 glyph to 8E → `value=16'h123F` after two frames; one new `frame_pulse`.
- **Reset and dp:** with `SEG_DP_CAPTURE_EN`, digit 2 BCD=24 (2 with dp) → `dp_mask=4'b0100`; `reset` mid-frame → all outputs 0, and a new publish needs 2 full frames.
